// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Holds the scheduler FSM encoding and default sizing.
package uart_tx_scheduler_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DIVW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_BUSY   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_arb.sv
// Round-robin arbiter: one-hot winner among req & mask,
// searching from the requester after ptr.
module uart_rr_arb_m
  import uart_tx_scheduler_pkg::*;
#(
  parameter  int unsigned N  = NREQ_DEF,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] elig;
  logic [PW:0]  idx;
  logic         found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    elig  = req & mask;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && elig[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ byte sources, with
// round-robin arbitration, packet locking and a bit-tick divider.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  parameter  int unsigned DIVW = DIVW_DEF,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIVW-1:0]   div,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              txbusy,
  output logic              bitxce,
  output logic              load,
  output logic [7:0]        d,
  output logic [NREQ-1:0]   grant,
  output logic              locked
);

  sched_state_e    state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            bitxce_q, bitxce_d;
  logic            load_q, load_d;
  logic            locked_q, locked_d;
  logic [7:0]      d_q, d_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] mask, win;
  logic [PW-1:0]   win_idx;
  logic [7:0]      win_data;
  logic            win_last;
  logic            accept;

  // While a packet is open only its owner may win.
  assign mask = locked_q ? grant_q : {NREQ{1'b1}};

  uart_rr_arb_m #(.N(NREQ)) u_arb (
    .req  (req_valid),
    .mask (mask),
    .ptr  (ptr_q),
    .gnt  (win)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_idx  = PW'(i);
        win_data = req_data[8*i +: 8];
        win_last = req_last[i];
      end
    end
  end

  assign accept = rst_n && (state_q == ST_IDLE) && en
               && !txbusy && (|win);

  assign req_ready = win & {NREQ{accept}};

  always_comb begin
    cnt_d    = cnt_q - 1'b1;
    bitxce_d = 1'b0;
    if (cnt_q == '0) begin
      cnt_d    = div;
      bitxce_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_d   = 1'b0;
    d_d      = d_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_LOAD;
          load_d   = 1'b1;
          d_d      = win_data;
          grant_d  = win;
          locked_d = !win_last;
          ptr_d    = win_idx;
        end
      end
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_BUSY;
      ST_BUSY: begin
        if (!txbusy) begin
          state_d = ST_IDLE;
          if (!locked_q) begin
            grant_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitxce_q <= 1'b0;
      load_q   <= 1'b0;
      d_q      <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
      ptr_q    <= PW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitxce_q <= bitxce_d;
      load_q   <= load_d;
      d_q      <= d_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bitxce = bitxce_q;
  assign load   = load_q;
  assign d      = d_q;
  assign grant  = grant_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed table,
// corner-case sequences and randomized traffic vs a reference model.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int DIVW = 16;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [DIVW-1:0]   div;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              txbusy;
  logic              bitxce;
  logic              load;
  logic [7:0]        d;
  logic [NREQ-1:0]   grant;
  logic              locked;

  logic ext_busy;
  logic mdl_busy;
  assign txbusy = ext_busy | mdl_busy;

  uart_tx_scheduler #(.NREQ(NREQ), .DIVW(DIVW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div       (div),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .txbusy    (txbusy),
    .bitxce    (bitxce),
    .load      (load),
    .d         (d),
    .grant     (grant),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference model: arbitration rules and transmitter busy time.
  int              cyc = 0;
  int              m_ptr = NREQ - 1;
  logic            m_locked = 1'b0;
  int              m_owner = 0;
  logic            pend = 1'b0;
  logic [7:0]      exp_d;
  logic [NREQ-1:0] exp_g;
  logic [NREQ-1:0] ew;
  int              busy_cnt = 0;
  int              busy_len = 10;
  int              prev_len = 0;
  logic            has_prev = 1'b0;
  int              last_load_cyc = 0;
  int              last_gap = 0;
  int              load_cnt = 0;
  int              acc_cnt = 0;
  int              acc_idx = 0;
  int              mw, ma;

  function automatic int exp_winner(input logic [NREQ-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr    = NREQ - 1;
      m_locked = 1'b0;
      m_owner  = 0;
      pend     = 1'b0;
      busy_cnt = 0;
      mdl_busy = 1'b0;
      has_prev = 1'b0;
    end else begin
      if (load || pend) begin
        chk("load_strobe", load, pend);
        if (load && pend) begin
          chk("load_d", d, exp_d);
          chk("load_grant", grant, exp_g);
          chk("load_locked", locked, m_locked);
        end
        if (load) begin
          load_cnt++;
          if (has_prev) begin
            last_gap = cyc - last_load_cyc;
            chk("load_spacing", last_gap >= 3 + prev_len, 1);
          end
          has_prev      = 1'b1;
          last_load_cyc = cyc;
          prev_len      = busy_len;
        end
        pend = 1'b0;
      end
      if (req_ready != '0) begin
        mw = exp_winner(req_valid);
        ew = '0;
        if (mw >= 0) ew[mw] = 1'b1;
        chk("ready_winner", req_ready, ew);
        chk("ready_gate", {en, txbusy}, 2'b10);
        ma = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) ma = i;
        pend     = 1'b1;
        exp_d    = req_data[8*ma +: 8];
        exp_g    = '0;
        exp_g[ma] = 1'b1;
        m_ptr    = ma;
        m_owner  = ma;
        m_locked = !req_last[ma];
        acc_idx  = ma;
        acc_cnt++;
      end
      mdl_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (load) busy_cnt = busy_len;
    end
  end

  task automatic wait_acc(input int budget, output bit ok);
    int c0;
    c0 = acc_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != c0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("acc_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] l;
    int              win;
    logic            lk;
    int              gap;
  } vec_t;

  vec_t            tbl [12];
  logic [8:0]      strm [NREQ][16];
  int              slen [NREQ];
  int              head [NREQ];
  logic [11:0]     got12, exp12;
  logic [7:0]      got8, exp8;
  logic [7:0]      b;
  bit              ok, found, done;
  int              c0, l0, seen, total, a0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; div = 16'd3; ext_busy = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    tbl[0]  = '{4'b1111, 4'b1111, 0, 1'b0, 0};
    tbl[1]  = '{4'b1111, 4'b1111, 1, 1'b0, 13};
    tbl[2]  = '{4'b1111, 4'b1111, 2, 1'b0, 13};
    tbl[3]  = '{4'b1111, 4'b1111, 3, 1'b0, 13};
    tbl[4]  = '{4'b1111, 4'b1111, 0, 1'b0, 13};
    tbl[5]  = '{4'b0100, 4'b0000, 2, 1'b1, 13};
    tbl[6]  = '{4'b0110, 4'b0000, 2, 1'b1, 13};
    tbl[7]  = '{4'b0110, 4'b0100, 2, 1'b0, 13};
    tbl[8]  = '{4'b0110, 4'b1111, 1, 1'b0, 13};
    tbl[9]  = '{4'b1001, 4'b1111, 3, 1'b0, 13};
    tbl[10] = '{4'b1001, 4'b1111, 0, 1'b0, 13};
    tbl[11] = '{4'b1111, 4'b1111, 1, 1'b0, 13};

    idle_cycles(3);
    chk("reset_outputs",
        {load, d, grant, locked, req_ready, bitxce}, '0);
    rst_n = 1'b1;

    // Bit tick: period div+1, then a mid-count div change.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = bitxce;
    end
    chk("tick_first", found, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      got12[k-1] = bitxce;
      exp12[k-1] = (k % 4 == 0);
    end
    chk("tick_div3", got12, exp12);
    @(posedge clk); #1;
    div = 16'd0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      got8[k-1] = bitxce;
      exp8[k-1] = (k >= 4);
    end
    chk("tick_div0", got8, exp8);
    div = 16'd3;

    // Directed arbitration table, 10-clock transmitter.
    busy_len = 10;
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      req_data  = $urandom;
      b = req_data[8*tbl[i].win +: 8];
      wait_acc(100, ok);
      chk("tbl_win", acc_idx, tbl[i].win);
      idle_cycles(1);
      chk("tbl_d", d, b);
      chk("tbl_locked", locked, tbl[i].lk);
      if (tbl[i].gap != 0) chk("tbl_gap", last_gap, tbl[i].gap);
    end

    // Locked packet from requester 2 while requester 1 waits.
    req_valid = 4'b0110; req_last = 4'b0010;
    req_data  = 32'h00_55_11_00;
    wait_acc(100, ok);
    chk("lock_first_win", acc_idx, 2);
    idle_cycles(1);
    chk("lock_first_d", d, 8'h55);
    chk("lock_set", locked, 1);
    req_valid = 4'b0010;
    c0 = acc_cnt;
    idle_cycles(40);
    chk("lock_hold_noacc", acc_cnt, c0);
    chk("lock_hold_grant", {locked, grant}, 5'b10100);
    req_valid = 4'b0110; req_last = 4'b0110;
    req_data  = 32'h00_AA_11_00;
    wait_acc(100, ok);
    chk("lock_second_win", acc_idx, 2);
    req_valid = 4'b0010;
    idle_cycles(1);
    chk("lock_second_d", {locked, d}, 9'h0AA);
    wait_acc(100, ok);
    chk("lock_after_win", acc_idx, 1);
    req_valid = '0;
    idle_cycles(1);
    chk("lock_after_d", d, 8'h11);
    idle_cycles(20);
    chk("grant_idle_clear", grant, '0);

    // en low during BUSY: byte finishes, nothing new.
    req_valid = 4'b0001; req_last = 4'b1111;
    req_data  = 32'h0000_003C;
    l0 = load_cnt;
    wait_acc(100, ok);
    chk("en_win", acc_idx, 0);
    idle_cycles(5);
    en = 1'b0;
    c0 = acc_cnt;
    idle_cycles(40);
    chk("en_cur_load", load_cnt - l0, 1);
    chk("en_low_noacc", acc_cnt, c0);
    en = 1'b1;
    wait_acc(100, ok);
    chk("en_resume_win", acc_idx, 0);
    req_valid = '0;
    idle_cycles(20);

    // txbusy held high in IDLE blocks acceptance.
    ext_busy  = 1'b1;
    req_valid = 4'b1010;
    c0 = acc_cnt; l0 = load_cnt;
    idle_cycles(30);
    chk("busy_noacc", acc_cnt, c0);
    chk("busy_noload", load_cnt, l0);
    ext_busy = 1'b0;
    wait_acc(100, ok);
    chk("busy_release_win", acc_idx, 1);
    req_valid = '0;
    idle_cycles(20);

    // Reset in BUSY aborts; requester 0 wins first after.
    req_valid = 4'b0001; req_data = 32'h0000_0081;
    wait_acc(100, ok);
    chk("rst_pre_win", acc_idx, 0);
    req_valid = '0;
    idle_cycles(4);
    rst_n = 1'b0;
    #1;
    chk("rst_async_zero",
        {load, d, grant, locked, req_ready, bitxce}, '0);
    idle_cycles(3);
    rst_n = 1'b1;
    l0 = load_cnt;
    idle_cycles(8);
    chk("rst_no_load", load_cnt, l0);
    req_valid = 4'b0101;
    wait_acc(100, ok);
    chk("rst_first_win", acc_idx, 0);
    req_valid = '0;
    idle_cycles(20);

    // Randomized traffic against the reference model.
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      slen[i] = $urandom_range(6, 16);
      head[i] = 0;
      total  += slen[i];
      for (int j = 0; j < 16; j++) begin
        strm[i][j][7:0] = 8'($urandom);
        strm[i][j][8]   = ($urandom_range(0, 2) == 0)
                       || (j == slen[i] - 1);
      end
    end
    a0   = acc_cnt;
    seen = acc_cnt;
    done = 1'b0;
    for (int t = 0; t < 8000 && !done; t++) begin
      @(posedge clk); #1;
      if (acc_cnt != seen) begin
        seen = acc_cnt;
        if (head[acc_idx] < slen[acc_idx]) head[acc_idx]++;
      end
      done = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (head[i] < slen[i]) begin
          done = 1'b0;
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_data[8*i +: 8] = strm[i][head[i]][7:0];
          req_last[i] = strm[i][head[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = '0;
          req_last[i] = 1'b0;
        end
      end
      en       = ($urandom_range(0, 15) != 0);
      ext_busy = ($urandom_range(0, 19) == 0);
      busy_len = $urandom_range(1, 6);
    end
    req_valid = '0; en = 1'b1; ext_busy = 1'b0;
    chk("rand_drain", done, 1);
    chk("rand_count", acc_cnt - a0, total);
    idle_cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one transmitter (2..8).
REQ-002 Parameter: DIVW, 16, width of the bit-tick divisor.
REQ-003 Port: clk  input  1  system clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  high = new grants allowed; low = finish current byte, grant nothing new.
REQ-006 Port: div  input  DIVW  bit-tick divisor; bitxce period = div+1 clocks.
REQ-007 Port: req_valid  input  NREQ  per-requester byte available.
REQ-008 Port: req_last  input  NREQ  per-requester end of packet, qualified by req_valid.
REQ-009 Port: req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-010 Port: req_ready  output  NREQ  one-hot acceptance pulse, combinational.
REQ-011 Port: txbusy  input  1  transmitter busy status.
REQ-012 Port: bitxce  output  1  registered one-cycle tick to transmitter/receiver divider.
REQ-013 Port: load  output  1  registered one-cycle load strobe to transmitter.
REQ-014 Port: d  output  8  registered byte to transmitter, valid while load high.
REQ-015 Port: grant  output  NREQ  registered one-hot owner of current byte/packet; zero when idle and unlocked.
REQ-016 Port: locked  output  1  packet in progress, owner held.

Function
REQ-017 Tick counter SHALL count down from div to 0; bitxce SHALL be high the cycle after reaching 0, counter reloading div; div change SHALL take effect at next reload.
REQ-018 FSM states SHALL be IDLE, LOAD, SETTLE, BUSY.
REQ-019 IDLE: if en, txbusy=0 and an eligible req_valid exists, the scheduler SHALL pulse req_ready for the winner, capture its byte into d, set grant, go LOAD; otherwise stay IDLE.
REQ-020 LOAD: load SHALL be high exactly this one cycle; next state SETTLE.
REQ-021 SETTLE: one cycle unconditionally (transmitter raises txbusy); next state BUSY.
REQ-022 BUSY: remain while txbusy=1; on txbusy=0 go IDLE.
REQ-023 Minimum spacing between load pulses SHALL be 3 clocks plus txbusy duration.
REQ-024 Unlocked arbitration SHALL be round-robin: search starts at requester after the last winner; after reset requester 0 has highest priority.
REQ-025 If accepted byte has req_last=0, locked SHALL set and only the owner is eligible until a byte with req_last=1 is accepted, which clears locked at acceptance.
REQ-026 While locked, other requesters' req_valid SHALL be ignored even if owner is not valid; en low SHALL not break the lock.
REQ-027 grant SHALL clear on return to IDLE unless locked.
REQ-028 Simultaneous requests: exactly one req_ready bit SHALL assert; req_valid dropped before acceptance SHALL not be accepted.
REQ-029 txbusy=1 in IDLE (external or stale) SHALL block acceptance.

Reset
REQ-030 On rst_n low: state IDLE, load=0, d=0, grant=0, locked=0, req_ready=0, bitxce=0, tick counter=0, round-robin pointer to requester NREQ-1 (so 0 wins first).
REQ-031 Reset mid-byte SHALL abort immediately; no load pulse after deassertion until a new acceptance.

Structure
REQ-032 Shared package SHALL hold FSM state encodings and NREQ/DIVW defaults.
REQ-033 Round-robin arbiter SHALL be one sub-module, uart_rr_arb_m (req, mask, pointer -> one-hot winner).

Verification
REQ-034 div=3: bitxce high 1 cycle every 4 clocks; change div to 0 mid-count -> every clock after next reload.
REQ-035 req_valid=4'b1111, all last=1, txbusy modelled 10 clocks -> grants 0,1,2,3,0 in order, load spacing 13 clocks.
REQ-036 Requester 2 sends 0x55 last=0, 0xAA last=1 while requester 1 valid -> 0x55, 0xAA then requester 1; locked high between.
REQ-037 en=0 during BUSY with requester 0 valid -> current byte completes, no further load until en=1.
REQ-038 rst_n low in BUSY -> all outputs zero asynchronously; after release requester 0 wins first.
REQ-039 txbusy held 1 in IDLE with requests -> no req_ready, no load until txbusy=0.
